alu_ctrl_sequencer: RTL

- Upstream neighbour of the adiabatic ALU. Buffers incoming 16-bit instructions and, at each Bennett-clock instruction boundary (instFlag rising edge), decodes one instruction into the ALU control/mux select bits.
- Generates single-cycle slow-clock pulses (ALU_O_Fclkpos, A_Fclkpos) at the full-swing point of the Bennett clock.
- Includes a watchdog that flags Bennett windows in which no full-swing point occurs.

---
 rtl/alu_ctrl_sequencer_if.sv | 8 +
 rtl/alu_ctrl_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer_if.sv
// alu_ctrl_sequencer_if: instruction valid/ready handshake into the sequencer
interface alu_ctrl_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr_in;
  logic        instr_ready;
  modport master (output instr_valid, instr_in, input instr_ready);
  modport slave (input instr_valid, instr_in, output instr_ready);
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: buffers instructions, decodes one per Bennett window, fires one slow-clock pulse at full swing
module alu_ctrl_sequencer #(
  parameter int WIDTH = 13,
  parameter int TIMEOUT = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instFlag,
  input  logic [WIDTH-1:0] clkpos,
  input  logic [WIDTH-1:0] clkneg,
  alu_ctrl_sequencer_if.slave up,
  output logic             ALU_Control0,
  output logic             ALU_Control1,
  output logic             A_mux,
  output logic             B_mux0,
  output logic             B_mux1,
  output logic             SUB,
  output logic             STL,
  output logic             Adder_Cin,
  output logic             mux3_0,
  output logic             mux3_1,
  output logic             ALU_O_Fclkpos,
  output logic             A_Fclkpos,
  output logic             busy,
  output logic             timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, DONE} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [TW-1:0] wd, wd_n;
  logic [7:0] ctrl, ctrl_n, dec;
  logic flag_d, rise, full_swing, push, pop, empty, err_n;
  assign rise = instFlag & ~flag_d;
  assign full_swing = (&clkpos) & ~(|clkneg);
  assign empty = cnt == '0;
  assign up.instr_ready = cnt != CW'(DEPTH);
  assign push = up.instr_valid & up.instr_ready;
  always_comb begin
    case (mem[rp][15:12])
      4'h1: dec = 8'b10000111;
      4'h2: dec = 8'b10110111;
      4'h3: dec = 8'b00000111;
      4'h4: dec = 8'b01000111;
      4'h5: dec = 8'b11111111;
      4'h6: dec = 8'b10000101;
      4'h7: dec = 8'b10000001;
      default: dec = 8'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    ctrl_n = ctrl;
    wd_n = wd;
    err_n = timeout_err;
    pop = 1'b0;
    if (rise) begin
      err_n = timeout_err | (state == ARMED);
      pop = ~empty;
      ctrl_n = empty ? 8'b0 : dec;
      state_n = (empty || dec == 8'b0) ? DONE : ARMED;
      wd_n = '0;
    end else if (state == ARMED) begin
      if (full_swing) state_n = FIRE;
      else if (wd == TW'(TIMEOUT - 1)) begin
        err_n = 1'b1;
        ctrl_n = 8'b0;
        state_n = DONE;
      end else wd_n = wd + 1'b1;
    end else if (state == FIRE) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ctrl <= 8'b0;
      wd <= '0;
      timeout_err <= 1'b0;
      flag_d <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ctrl <= ctrl_n;
      wd <= wd_n;
      timeout_err <= err_n;
      flag_d <= instFlag;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= up.instr_in;
  assign {ALU_Control1, ALU_Control0, SUB, Adder_Cin, STL, A_mux, B_mux1, B_mux0} = ctrl;
  assign {mux3_1, mux3_0} = 2'b00;
  assign ALU_O_Fclkpos = state == FIRE;
  assign A_Fclkpos = state == FIRE;
  assign busy = state == ARMED || state == FIRE;
endmodule
